// File: rtl/sort_mem_pkg.sv
// Shared types and helpers for the sort-engine memory with compare-and-swap.
package sort_mem_pkg;

  // Operands are extended to this width before comparing; DATA_WIDTH must not exceed it.
  localparam int unsigned CMP_WIDTH = 64;

  localparam int unsigned STATE_WIDTH = 3;
  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD    = 3'd1;
  localparam state_t SWAP_LO = 3'd2;
  localparam state_t SWAP_HI = 3'd3;
  localparam state_t DONE    = 3'd4;

  // True when the pair (a, b) violates the requested order; equal words never swap.
  function automatic logic out_of_order(input logic [CMP_WIDTH-1:0] a,
                                        input logic [CMP_WIDTH-1:0] b,
                                        input logic                 descending,
                                        input logic                 signed_mode);
    logic gt;
    logic lt;
    if (signed_mode) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return descending ? lt : gt;
  endfunction

endpackage

// File: rtl/sort_mem_array.sv
// Word storage: one clocked write port, two combinational read ports.
module sort_mem_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clocked write; addresses beyond DEPTH are ignored.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational reads; addresses beyond DEPTH read as zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (32'(raddr_a) < DEPTH) rdata_a = mem[raddr_a];
    if (32'(raddr_b) < DEPTH) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/sort_mem_swap_unit.sv
// Sort-engine memory: host read/write port plus an adjacent-pair compare-and-swap command.
module sort_mem_swap_unit
  import sort_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  cmp_start,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  input  logic                  descending,
  output logic                  busy,
  output logic                  done,
  output logic                  swapped,
  output logic                  cmp_err
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
  logic                  lat_desc, lat_desc_nxt;
  logic                  lat_err, lat_err_nxt;
  logic [DATA_WIDTH-1:0] word_a, word_a_nxt;
  logic [DATA_WIDTH-1:0] word_b, word_b_nxt;
  logic                  busy_nxt, done_nxt, swapped_nxt, cmp_err_nxt;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [CMP_WIDTH-1:0]  cmp_a, cmp_b;

  // Upper word of the pair; cannot wrap because accepted addresses are below DEPTH-1.
  assign addr_hi = lat_addr + ADDR_WIDTH'(1);

  // Port a serves the host except in LOAD, where it fetches the lower operand.
  assign raddr_a  = (state == LOAD) ? lat_addr : addr;
  assign data_out = mem_read ? rdata_a : '0;

  sort_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (addr_hi),
    .rdata_b (rdata_b)
  );

  // Extend operands to the compare width with the configured signedness.
  always_comb begin
    if (SIGNED != 0) begin
      cmp_a = CMP_WIDTH'($signed(rdata_a));
      cmp_b = CMP_WIDTH'($signed(rdata_b));
    end else begin
      cmp_a = CMP_WIDTH'(rdata_a);
      cmp_b = CMP_WIDTH'(rdata_b);
    end
  end

  // Next-state, write-port mux and next values of the registered outputs.
  always_comb begin
    state_nxt    = state;
    lat_addr_nxt = lat_addr;
    lat_desc_nxt = lat_desc;
    lat_err_nxt  = lat_err;
    word_a_nxt   = word_a;
    word_b_nxt   = word_b;
    swapped_nxt  = swapped;
    cmp_err_nxt  = cmp_err;
    we           = 1'b0;
    waddr        = addr;
    wdata        = data_in;

    case (state)
      IDLE: begin
        we = mem_write;
        if (cmp_start) begin
          lat_addr_nxt = cmp_addr;
          lat_desc_nxt = descending;
          lat_err_nxt  = (32'(cmp_addr) >= (DEPTH - 1));
          swapped_nxt  = 1'b0;
          cmp_err_nxt  = 1'b0;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        word_a_nxt = rdata_a;
        word_b_nxt = rdata_b;
        if (lat_err) begin
          cmp_err_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (out_of_order(cmp_a, cmp_b, lat_desc, SIGNED != 0)) begin
          state_nxt = SWAP_LO;
        end else begin
          state_nxt = DONE;
        end
      end
      SWAP_LO: begin
        we        = 1'b1;
        waddr     = lat_addr;
        wdata     = word_b;
        state_nxt = SWAP_HI;
      end
      SWAP_HI: begin
        we          = 1'b1;
        waddr       = addr_hi;
        wdata       = word_a;
        swapped_nxt = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // State, latched operands and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_desc <= 1'b0;
      lat_err  <= 1'b0;
      word_a   <= '0;
      word_b   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      swapped  <= 1'b0;
      cmp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_addr <= lat_addr_nxt;
      lat_desc <= lat_desc_nxt;
      lat_err  <= lat_err_nxt;
      word_a   <= word_a_nxt;
      word_b   <= word_b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      swapped  <= swapped_nxt;
      cmp_err  <= cmp_err_nxt;
    end
  end

endmodule

// File: tb/tb_sort_mem_swap_unit.sv
// Directed bench: an unsigned and a signed instance share all stimulus.
module tb_sort_mem_swap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [9:0]  addr;
  logic [15:0] data_in;
  logic        cmp_start;
  logic [9:0]  cmp_addr;
  logic        descending;

  logic [15:0] dout0, dout1;
  logic        busy0, done0, sw0, err0;
  logic        busy1, done1, sw1, err1;

  int checks = 0;
  int errors = 0;
  int c0, c1, p0;
  logic [15:0] r0, r1;

  always #5 clk = ~clk;

  sort_mem_swap_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(1024), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .data_in(data_in), .data_out(dout0), .cmp_start(cmp_start), .cmp_addr(cmp_addr),
    .descending(descending), .busy(busy0), .done(done0), .swapped(sw0), .cmp_err(err0)
  );

  sort_mem_swap_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(1024), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .data_in(data_in), .data_out(dout1), .cmp_start(cmp_start), .cmp_addr(cmp_addr),
    .descending(descending), .busy(busy1), .done(done1), .swapped(sw1), .cmp_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; one host write crossing the next posedge.
  task automatic host_write(input logic [9:0] a, input logic [15:0] d);
    mem_write = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic host_read(input logic [9:0] a);
    mem_read = 1'b1; addr = a;
    #1;
    r0 = dout0; r1 = dout1;
    mem_read = 1'b0;
  endtask

  // Issue a command at a negedge and watch 8 cycles; c0/c1 = cycle of first done, p0 = pulses.
  task automatic cmd(input logic [9:0] a, input logic desc, input int hold,
                     input logic wr_en, input int wr_cyc, input logic [9:0] wa, input logic [15:0] wd);
    c0 = 0; c1 = 0; p0 = 0;
    cmp_start = 1'b1; cmp_addr = a; descending = desc;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (wr_en && cyc == wr_cyc) begin
        mem_write = 1'b1; addr = wa; data_in = wd;
      end
      @(negedge clk);
      mem_write = 1'b0;
      if (cyc >= hold) cmp_start = 1'b0;
      if (done0) begin
        p0++;
        if (c0 == 0) c0 = cyc + 1;
      end
      if (done1 && c1 == 0) c1 = cyc + 1;
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; data_in = '0;
    cmp_start = 1'b0; cmp_addr = '0; descending = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_done", 32'(done0), 32'(0));
    chk("rst_swapped", 32'(sw0), 32'(0));
    chk("rst_err", 32'(err0), 32'(0));
    mem_read = 1'b0; addr = 10'd0; #1;
    chk("read_disabled_zero", 32'(dout0), 32'(0));

    // Ascending swap
    host_write(10'd4, 16'h0030);
    host_write(10'd5, 16'h0010);
    cmd(10'd4, 1'b0, 0, 1'b0, 0, 10'd0, 16'h0);
    chk("asc_done_cycle", 32'(c0), 32'(4));
    chk("asc_pulses", 32'(p0), 32'(1));
    chk("asc_swapped_held", 32'(sw0), 32'(1));
    chk("asc_busy_after", 32'(busy0), 32'(0));
    host_read(10'd4); chk("asc_mem4", 32'(r0), 32'h0010);
    host_read(10'd5); chk("asc_mem5", 32'(r0), 32'h0030);

    // Descending, already ordered
    host_write(10'd4, 16'h0030);
    host_write(10'd5, 16'h0010);
    cmd(10'd4, 1'b1, 0, 1'b0, 0, 10'd0, 16'h0);
    chk("desc_done_cycle", 32'(c0), 32'(2));
    chk("desc_swapped", 32'(sw0), 32'(0));
    host_read(10'd4); chk("desc_mem4", 32'(r0), 32'h0030);
    host_read(10'd5); chk("desc_mem5", 32'(r0), 32'h0010);

    // Equal words never swap
    host_write(10'd8, 16'h0022);
    host_write(10'd9, 16'h0022);
    cmd(10'd8, 1'b0, 0, 1'b0, 0, 10'd0, 16'h0);
    chk("eq_asc_swapped", 32'(sw0), 32'(0));
    chk("eq_asc_cycle", 32'(c0), 32'(2));
    cmd(10'd8, 1'b1, 0, 1'b0, 0, 10'd0, 16'h0);
    chk("eq_desc_swapped", 32'(sw0), 32'(0));

    // Signed vs unsigned compare of 0xFFFF / 0x0001
    host_write(10'd0, 16'hFFFF);
    host_write(10'd1, 16'h0001);
    cmd(10'd0, 1'b0, 0, 1'b0, 0, 10'd0, 16'h0);
    chk("uns_done_cycle", 32'(c0), 32'(4));
    chk("uns_swapped", 32'(sw0), 32'(1));
    chk("sgn_done_cycle", 32'(c1), 32'(2));
    chk("sgn_swapped", 32'(sw1), 32'(0));
    host_read(10'd0);
    chk("uns_mem0", 32'(r0), 32'h0001);
    chk("sgn_mem0", 32'(r1), 32'hFFFF);

    // Out-of-range address; start held while busy must not re-trigger
    host_write(10'd1023, 16'hABCD);
    cmd(10'd1023, 1'b0, 2, 1'b0, 0, 10'd0, 16'h0);
    chk("err_done_cycle", 32'(c0), 32'(2));
    chk("err_pulses", 32'(p0), 32'(1));
    chk("err_flag", 32'(err0), 32'(1));
    chk("err_swapped_cleared", 32'(sw0), 32'(0));
    host_read(10'd1023); chk("err_mem1023", 32'(r0), 32'hABCD);
    host_read(10'd0);    chk("err_mem0", 32'(r0), 32'h0001);

    // Host write in the accept cycle is visible to LOAD
    host_write(10'd6, 16'h0009);
    host_write(10'd7, 16'h0100);
    cmd(10'd6, 1'b0, 0, 1'b1, 0, 10'd7, 16'h0005);
    chk("samecyc_done_cycle", 32'(c0), 32'(4));
    chk("samecyc_swapped", 32'(sw0), 32'(1));
    chk("samecyc_err_cleared", 32'(err0), 32'(0));
    host_read(10'd6); chk("samecyc_mem6", 32'(r0), 32'h0005);
    host_read(10'd7); chk("samecyc_mem7", 32'(r0), 32'h0009);

    // Host write while busy is dropped
    host_write(10'd10, 16'h0001);
    host_write(10'd11, 16'h0002);
    host_write(10'd12, 16'h0055);
    cmd(10'd10, 1'b0, 0, 1'b1, 1, 10'd12, 16'h0077);
    chk("busywr_swapped", 32'(sw0), 32'(0));
    host_read(10'd12); chk("busywr_mem12", 32'(r0), 32'h0055);

    // Reset while in SWAP_HI leaves the pair half-swapped
    host_write(10'd4, 16'h0030);
    host_write(10'd5, 16'h0010);
    cmp_start = 1'b1; cmp_addr = 10'd4; descending = 1'b0;
    @(negedge clk);
    cmp_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy0), 32'(1));
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy0), 32'(0));
    chk("midrst_done", 32'(done0), 32'(0));
    chk("midrst_swapped", 32'(sw0), 32'(0));
    chk("midrst_err", 32'(err0), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_read(10'd4); chk("midrst_mem4", 32'(r0), 32'h0010);
    host_read(10'd5); chk("midrst_mem5", 32'(r0), 32'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
